dpram_port_arbiter: RTL

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

---
 rtl/dpram_pkg.sv | 8 +
 rtl/dpram_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dpram_pkg.sv
// Shared types and default sizes for the dual-port RAM arbiter.
package dpram_pkg;
  localparam int DEF_AW        = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
endpackage

// File: rtl/dpram_port_arbiter.sv
// Two requesters onto one external single-port RAM, with locked bursts bounded under contention.
// Define DPRAM_ARB_RR_EN for round-robin on contended idle grants; otherwise port 0 has fixed priority.
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_0,
  input  logic          we_0,
  input  logic          lock_0,
  input  logic [AW-1:0] addr_0,
  input  logic [DW-1:0] wdata_0,
  input  logic          req_1,
  input  logic          we_1,
  input  logic          lock_1,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_1,
  output logic          gnt_0,
  output logic          gnt_1,
  output logic          rvalid_0,
  output logic          rvalid_1,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] beat_cnt_q, beat_cnt_d, beat_inc;
  logic       rvalid_0_q, rvalid_1_q;

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req_0 && req_1) begin
            gnt_0 = !prio_q;
            gnt_1 = prio_q;
          end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
          end
        end
        OWN0:    gnt_0 = req_0;
        OWN1:    gnt_1 = req_1;
        default: ;
      endcase
    end
  end

  assign beat_inc = (beat_cnt_q >= MAXB) ? MAXB : beat_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_0 && lock_0) begin
          state_d    = OWN0;
          beat_cnt_d = 4'd1;
        end else if (gnt_1 && lock_1) begin
          state_d    = OWN1;
          beat_cnt_d = 4'd1;
        end
        // A pending handover priority is consumed by the next contended grant.
        if (req_0 && req_1) begin
`ifdef DPRAM_ARB_RR_EN
          prio_d = gnt_0;
`else
          prio_d = 1'b0;
`endif
        end
      end
      OWN0: begin
        if (!req_0 || !lock_0) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
        end else if (beat_inc == MAXB && req_1) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
          prio_d     = 1'b1;
        end else begin
          beat_cnt_d = beat_inc;
        end
      end
      OWN1: begin
        if (!req_1 || !lock_1) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
        end else if (beat_inc == MAXB && req_0) begin
          state_d    = IDLE;
          beat_cnt_d = 4'd0;
          prio_d     = 1'b0;
        end else begin
          beat_cnt_d = beat_inc;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      beat_cnt_q <= 4'd0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_0_q <= gnt_0 && !we_0;
      rvalid_1_q <= gnt_1 && !we_1;
    end
  end

  assign ram_en    = gnt_0 || gnt_1;
  assign ram_we    = gnt_0 ? we_0    : (gnt_1 ? we_1    : 1'b0);
  assign ram_addr  = gnt_0 ? addr_0  : (gnt_1 ? addr_1  : '0);
  assign ram_wdata = gnt_0 ? wdata_0 : (gnt_1 ? wdata_1 : '0);
  assign rvalid_0  = rvalid_0_q;
  assign rvalid_1  = rvalid_1_q;
  assign rdata     = ram_rdata;

endmodule
